if_stage_nested_irq: RTL and testbench

//  Instruction-fetch PC unit for the pipeline front end. Selects the next PC from the redirect sources
//  (branch undo, PCR jump, interrupt return, predicted branch) and from up to NUM_IRQ prioritised interrupt lines.

---
 rtl/if_stage_nested_irq_if.sv | 45 ++++
 rtl/if_stage_nested_irq.sv | 128 ++++++++++++
 tb/tb_if_stage_nested_irq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_nested_irq_if.sv
// Front-end PC unit bundle: hazard/redirect/irq inputs toward the fetch
// PC unit, and fetch address / irq status outputs back to the pipeline.
// master: hazard unit / pipeline side.  slave: the fetch PC unit.
// Inputs to the unit:  stall, branch_predict/branch_pc, branch_undo/pc_not_taken,
//                      pcr_take/pcr, reti, irq_req[NUM_IRQ]
// Outputs of the unit: mem_addr, pc_plus_4, irq_taken, irq_id, in_isr,
//                      flush, stack_err
interface if_stage_nested_irq_if #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4,
    parameter int IDW     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
);
    logic               stall;
    logic               branch_predict;
    logic [XLEN-1:0]    branch_pc;
    logic               branch_undo;
    logic [XLEN-1:0]    pc_not_taken;
    logic               pcr_take;
    logic [XLEN-1:0]    pcr;
    logic               reti;
    logic [NUM_IRQ-1:0] irq_req;
    logic [XLEN-1:0]    mem_addr;
    logic [XLEN-1:0]    pc_plus_4;
    logic               irq_taken;
    logic [IDW-1:0]     irq_id;
    logic               in_isr;
    logic               flush;
    logic               stack_err;

    modport master (
        output stall, branch_predict, branch_pc,
        output branch_undo, pc_not_taken,
        output pcr_take, pcr, reti, irq_req,
        input  mem_addr, pc_plus_4, irq_taken,
        input  irq_id, in_isr, flush, stack_err
    );

    modport slave (
        input  stall, branch_predict, branch_pc,
        input  branch_undo, pc_not_taken,
        input  pcr_take, pcr, reti, irq_req,
        output mem_addr, pc_plus_4, irq_taken,
        output irq_id, in_isr, flush, stack_err
    );
endinterface

// File: rtl/if_stage_nested_irq.sv
// Instruction-fetch PC unit with prioritised, nestable interrupts.
// Ports: clk, rst_n (async, active-low), bus (slave modport of the bundle).
module if_stage_nested_irq #(
    parameter int              XLEN        = 32,
    parameter int              NUM_IRQ     = 4,
    parameter int              STACK_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter logic [XLEN-1:0] VEC_BASE    = 32'h0000_1000,
    parameter int              VEC_STRIDE  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    if_stage_nested_irq_if.slave bus
);
    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int LVW = $clog2(NUM_IRQ + 1);
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [LVW-1:0]  lvl_t;
    typedef logic [SPW-1:0]  sp_t;

    addr_t              pc_q, pc_d;
    sp_t                sp_q, sp_d;
    lvl_t               lvl_q, lvl_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    addr_t              stk_pc_q  [STACK_DEPTH];
    lvl_t               stk_lvl_q [STACK_DEPTH];

    logic           elig_v;
    logic [IDW-1:0] elig_id;
    addr_t          top_pc;
    lvl_t           top_lvl;
    addr_t          vec;
    logic           stk_empty, stk_full;
    logic           redirect, accept, pop, err;

    // Lowest index wins; only lines strictly above the running level.
    always_comb begin
        elig_v  = 1'b0;
        elig_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_q[i] && (LVW'(i) < lvl_q)) begin
                elig_v  = 1'b1;
                elig_id = IDW'(i);
            end
        end
    end

    always_comb begin
        top_pc  = '0;
        top_lvl = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (SPW'(i + 1) == sp_q) begin
                top_pc  = stk_pc_q[i];
                top_lvl = stk_lvl_q[i];
            end
        end
    end

    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SPW'(STACK_DEPTH));
    assign redirect  = bus.branch_undo | bus.pcr_take;
    assign accept    = elig_v & ~bus.stall & ~redirect
                     & ~bus.reti & ~stk_full;
    // A reti shadowed by a redirect is dropped entirely.
    assign pop       = bus.reti & ~redirect & ~stk_empty;
    assign err       = bus.reti & ~redirect & stk_empty;
    assign vec       = VEC_BASE
                     + addr_t'(elig_id) * addr_t'(VEC_STRIDE);

    always_comb begin
        pc_d = pc_q + addr_t'(4);
        if (bus.branch_undo)         pc_d = bus.pc_not_taken;
        else if (bus.pcr_take)       pc_d = bus.pcr;
        else if (pop)                pc_d = top_pc;
        else if (accept)             pc_d = vec;
        else if (bus.stall)          pc_d = pc_q;
        else if (bus.branch_predict) pc_d = bus.branch_pc;
    end

    always_comb begin
        sp_d   = sp_q;
        lvl_d  = lvl_q;
        pend_d = pend_q | bus.irq_req;
        if (accept) begin
            sp_d            = sp_q + SPW'(1);
            lvl_d           = lvl_t'(elig_id);
            pend_d[elig_id] = 1'b0;
        end else if (pop) begin
            sp_d  = sp_q - SPW'(1);
            lvl_d = top_lvl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            sp_q   <= '0;
            lvl_q  <= LVW'(NUM_IRQ);
            pend_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_pc_q[i]  <= '0;
                stk_lvl_q[i] <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            sp_q   <= sp_d;
            lvl_q  <= lvl_d;
            pend_q <= pend_d;
            // The interrupted (squashed) pc is saved so it is refetched.
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (accept && (sp_q == SPW'(i))) begin
                    stk_pc_q[i]  <= pc_q;
                    stk_lvl_q[i] <= lvl_q;
                end
            end
        end
    end

    assign bus.mem_addr  = rst_n ? pc_d : RESET_PC;
    assign bus.pc_plus_4 = pc_q + addr_t'(4);
    assign bus.irq_taken = accept;
    assign bus.irq_id    = accept ? elig_id : '0;
    assign bus.in_isr    = ~stk_empty;
    assign bus.flush     = rst_n & (redirect | accept | pop);
    assign bus.stack_err = rst_n & err;
endmodule

// File: tb/tb_if_stage_nested_irq.sv
// Directed bench for the fetch PC unit with nested interrupts.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_if_stage_nested_irq;
    logic clk;
    logic rst_n;
    int   ncmp;
    int   nfail;

    if_stage_nested_irq_if b ();

    if_stage_nested_irq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cyc(input string tag, input logic [31:0] addr,
                           input logic taken, input logic [31:0] id,
                           input logic fl);
        chk({tag, ".addr"}, b.mem_addr, addr);
        chk({tag, ".taken"}, 32'(b.irq_taken), 32'(taken));
        chk({tag, ".id"}, 32'(b.irq_id), id);
        chk({tag, ".flush"}, 32'(b.flush), 32'(fl));
    endtask

    task automatic run_to(input logic [31:0] target);
        for (int i = 0; i < 100; i++) begin
            if (b.mem_addr === target) break;
            @(negedge clk);
            #1;
        end
        chk("run_to", b.mem_addr, target);
    endtask

    initial begin
        ncmp  = 0;
        nfail = 0;
        rst_n = 1'b0;
        b.stall = 0; b.branch_predict = 0; b.branch_pc = '0;
        b.branch_undo = 0; b.pc_not_taken = '0;
        b.pcr_take = 0; b.pcr = '0; b.reti = 0; b.irq_req = '0;

        // Reset state
        @(negedge clk); #1;
        chk("rst.addr", b.mem_addr, 32'h0);
        chk("rst.pc4", b.pc_plus_4, 32'h4);
        chk("rst.isr", 32'(b.in_isr), 32'h0);
        chk("rst.taken", 32'(b.irq_taken), 32'h0);
        chk("rst.flush", 32'(b.flush), 32'h0);
        chk("rst.err", 32'(b.stack_err), 32'h0);

        // Sequential fetch, then a 2-cycle stall
        @(negedge clk); rst_n = 1'b1; #1;
        chk("seq0", b.mem_addr, 32'h4);
        @(negedge clk); #1;
        chk("seq1", b.mem_addr, 32'h8);
        @(negedge clk); b.stall = 1; #1;
        chk("stall0", b.mem_addr, 32'h8);
        @(negedge clk); #1;
        chk("stall1", b.mem_addr, 32'h8);
        @(negedge clk); b.stall = 0; #1;
        chk("unstall", b.mem_addr, 32'hC);

        // irq2 pulsed while fetching 0x40
        run_to(32'h40);
        b.irq_req = 4'b0100; #1;
        chk_cyc("pulse2", 32'h40, 0, 0, 0);
        @(negedge clk); b.irq_req = '0; #1;
        chk_cyc("acc2", 32'h1020, 1, 2, 1);
        @(negedge clk); #1;
        chk_cyc("isr2", 32'h1024, 0, 0, 0);
        chk("isr2.in", 32'(b.in_isr), 32'h1);

        // Nest irq0; irq3 must wait
        b.irq_req = 4'b1001; #1;
        chk_cyc("pulse03", 32'h1024, 0, 0, 0);
        @(negedge clk); b.irq_req = '0; #1;
        chk_cyc("acc0", 32'h1000, 1, 0, 1);
        @(negedge clk); #1;
        chk_cyc("isr0", 32'h1004, 0, 0, 0);
        @(negedge clk); b.reti = 1; #1;
        chk_cyc("reti0", 32'h1024, 0, 0, 1);
        @(negedge clk); b.reti = 0; #1;
        chk_cyc("back2", 32'h1028, 0, 0, 0);
        @(negedge clk); b.reti = 1; #1;
        chk_cyc("reti2", 32'h40, 0, 0, 1);
        @(negedge clk); b.reti = 0; #1;
        chk("ret.in_isr", 32'(b.in_isr), 32'h0);
        chk_cyc("acc3", 32'h1030, 1, 3, 1);

        // Fill the stack: 3 -> 2 -> 1 -> 0
        @(negedge clk); b.irq_req = 4'b0100; #1;
        chk_cyc("f.p2", 32'h1034, 0, 0, 0);
        @(negedge clk); b.irq_req = '0; #1;
        chk_cyc("f.a2", 32'h1020, 1, 2, 1);
        @(negedge clk); b.irq_req = 4'b0010; #1;
        chk_cyc("f.p1", 32'h1024, 0, 0, 0);
        @(negedge clk); b.irq_req = '0; #1;
        chk_cyc("f.a1", 32'h1010, 1, 1, 1);
        @(negedge clk); b.irq_req = 4'b0001; #1;
        chk_cyc("f.p0", 32'h1014, 0, 0, 0);
        @(negedge clk); b.irq_req = '0; #1;
        chk_cyc("f.a0", 32'h1000, 1, 0, 1);
        @(negedge clk); b.irq_req = 4'b1000; #1;
        chk_cyc("f.p3", 32'h1004, 0, 0, 0);
        @(negedge clk); b.irq_req = '0; #1;
        chk_cyc("f.blk", 32'h1008, 0, 0, 0);

        // Unwind with reti held 4 cycles, then irq3 resumes
        b.reti = 1; #1;
        chk_cyc("u.r0", 32'h1014, 0, 0, 1);
        @(negedge clk); #1;
        chk_cyc("u.r1", 32'h1024, 0, 0, 1);
        @(negedge clk); #1;
        chk_cyc("u.r2", 32'h1034, 0, 0, 1);
        @(negedge clk); #1;
        chk_cyc("u.r3", 32'h40, 0, 0, 1);
        @(negedge clk); b.reti = 0; #1;
        chk_cyc("u.a3", 32'h1030, 1, 3, 1);

        // reti on empty stack
        @(negedge clk); b.reti = 1; #1;
        chk_cyc("e.pop", 32'h40, 0, 0, 1);
        @(negedge clk); #1;
        chk_cyc("e.err", 32'h44, 0, 0, 0);
        chk("e.err_pulse", 32'(b.stack_err), 32'h1);
        chk("e.in_isr", 32'(b.in_isr), 32'h0);

        // undo + pcr + pending irq in one cycle
        @(negedge clk); b.reti = 0; b.irq_req = 4'b0010; #1;
        chk("r.noerr", 32'(b.stack_err), 32'h0);
        chk_cyc("r.p1", 32'h48, 0, 0, 0);
        @(negedge clk); b.irq_req = '0;
        b.branch_undo = 1; b.pc_not_taken = 32'h200;
        b.pcr_take = 1; b.pcr = 32'h300; #1;
        chk_cyc("r.undo", 32'h200, 0, 0, 1);
        @(negedge clk); b.branch_undo = 0; b.pcr_take = 0; #1;
        chk_cyc("r.a1", 32'h1010, 1, 1, 1);

        // undo beats reti: no pop
        @(negedge clk);
        b.branch_undo = 1; b.pc_not_taken = 32'h500; b.reti = 1; #1;
        chk_cyc("ur", 32'h500, 0, 0, 1);
        @(negedge clk); b.branch_undo = 0; b.reti = 0; #1;
        chk("ur.in_isr", 32'(b.in_isr), 32'h1);
        chk_cyc("ur.next", 32'h504, 0, 0, 0);

        // predicted branch and wraparound
        @(negedge clk);
        b.branch_predict = 1; b.branch_pc = 32'hFFFF_FFFC; #1;
        chk_cyc("bp", 32'hFFFF_FFFC, 0, 0, 0);
        @(negedge clk); b.branch_predict = 0; #1;
        chk("wrap.addr", b.mem_addr, 32'h0);
        chk("wrap.pc4", b.pc_plus_4, 32'h0);

        // Reset mid-ISR drops pending irq2
        b.irq_req = 4'b0100;
        @(negedge clk); b.irq_req = '0; #1;
        chk("m.taken", 32'(b.irq_taken), 32'h0);
        chk("m.in_isr", 32'(b.in_isr), 32'h1);
        rst_n = 1'b0; #1;
        chk("mr.in_isr", 32'(b.in_isr), 32'h0);
        chk("mr.addr", b.mem_addr, 32'h0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk_cyc("mr.s0", 32'h4, 0, 0, 0);
        @(negedge clk); #1;
        chk_cyc("mr.s1", 32'h8, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end
endmodule
